instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter PROG_DEPTH, default 16, program memory depth in 8-bit words; power of two, minimum 4.
REQ-002 Parameter NOP_WORD, default 8'h80, idle instruction driven to the processor (MOV with source and destination both A).
REQ-003 clk  input  1  rising-edge clock shared with the processor.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load_valid  input  1  program word offered for loading.
REQ-006 load_data  input  8  program word.
REQ-007 load_ready  output  1  load word accepted this cycle when load_valid is also high.
REQ-008 prog_clr  input  1  discard the loaded program (program length becomes 0).
REQ-009 start  input  1  begin execution at pc=0.
REQ-010 instr  output  8  instruction to the processor.
REQ-011 proc_in  output  8  operand to the processor's IN port.
REQ-012 proc_out  input  8  processor OUT port, sampled while an OUT instruction is driven.
REQ-013 res_valid, res_data  output  1/8  captured result.
REQ-014 res_ready  input  1  result consumed; meaningful only with RESULT_FIFO_EN.
REQ-015 busy, done, err  output  1 each  status flags.

Function
REQ-016 States: IDLE, RUN, DONE, encoded in 2 bits.
REQ-017 load_ready SHALL be state==IDLE && len<PROG_DEPTH && !start && !prog_clr.
- Accepted word is written to mem[len]; len increments; len width is log2(PROG_DEPTH)+1.
REQ-018 prog_clr in IDLE or DONE SHALL set len=0 and enter IDLE; it is ignored in RUN.
REQ-019 start in IDLE or DONE with len>0 SHALL enter RUN with pc=0; start with len=0 is ignored.
REQ-020 In RUN, each cycle SHALL drive instr=mem[pc] combinationally.
- Opcode instr[7:6]=00 (IN): proc_in=mem[pc+1] in the same cycle; pc+=2.
- Any other opcode: proc_in=8'h00; pc+=1.
REQ-021 An IN at pc=len-1 SHALL drive proc_in=8'h00, set sticky err, and advance pc by 1.
REQ-022 When the updated pc >= len, the state SHALL go from RUN to DONE; done=1 in DONE; busy=1 in RUN only.
REQ-023 Outside RUN, or while stalled, instr SHALL equal NOP_WORD and proc_in SHALL be 8'h00.
REQ-024 When an OUT (opcode 11) is issued, proc_out SHALL be captured at that clock edge.
- Captured value is visible on res_data with res_valid=1 from the next cycle (latency 1).
REQ-025 err is cleared only by rst or by an accepted start.

Reset
REQ-026 rst SHALL force the following, and overrides every other input in the same cycle:
- state=IDLE, len=0, pc=0, err=0
- res_valid=0, res_data=8'h00
- instr=NOP_WORD, proc_in=8'h00
REQ-027 rst asserted in RUN SHALL abort execution; memory contents need not be cleared because len=0.

Configuration
REQ-028 Macro RESULT_FIFO_EN, when defined, SHALL provide a 4-entry result FIFO.
- A result pops when res_valid && res_ready.
- If an OUT is pending and the FIFO is full, the sequencer SHALL drive NOP_WORD and hold pc (stall).
- A simultaneous push and pop on a full FIFO SHALL NOT stall.
REQ-029 Without RESULT_FIFO_EN, results SHALL go to a single register.
- res_valid pulses for one cycle per OUT; a new OUT overwrites the register.
- res_ready is ignored and the sequencer never stalls.

Structure
REQ-030 A shared package SHALL hold:
- Opcode constants OP_IN=2'b00, OP_ADD=2'b01, OP_MOV=2'b10, OP_OUT=2'b11.
- The state enum.
- Default NOP_WORD.
REQ-031 Sub-module result_fifo SHALL exist only under RESULT_FIFO_EN.
- Program memory is a flop array with two combinational read ports.

Verification
REQ-032 Basic program: load 00,05,88,41,C0 then start.
- Instr sequence 00 (proc_in=05), 88, 41, C0.
- res_data=0A one cycle after C0; done after 4 RUN cycles.
REQ-033 Truncated IN: load 00 only, then start.
- instr=00 with proc_in=00, err=1, DONE next cycle.
REQ-034 Full memory: load 17 words.
- load_ready drops after the 16th word; the 17th word is not written.
REQ-035 Start priority: assert start and load_valid together in IDLE with len=3.
- Load not accepted; RUN entered with len=3.
REQ-036 FIFO full (RESULT_FIFO_EN defined): program of six C0 words with res_ready=0.
- Four results captured; instr=NOP_WORD with pc held.
- Raising res_ready resumes execution, all six results delivered in order.
REQ-037 Reset mid-RUN: rst at pc=2.
- Next cycle: IDLE, len=0, instr=80, res_valid=0.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: opcodes, sequencer state type and default idle word shared by the sequencer files.
package instr_sequencer_pkg;
    localparam logic [1:0] OP_IN  = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_MOV = 2'b10;
    localparam logic [1:0] OP_OUT = 2'b11;
    localparam logic [7:0] NOP_WORD_DEF = 8'h80;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    function automatic logic [1:0] opcode(input logic [7:0] w);
        return w[7:6];
    endfunction
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: host/processor-facing signals of the sequencer; slave is the sequencer side.
interface instr_sequencer_if;
    logic       load_valid, load_ready, prog_clr, start;
    logic [7:0] load_data, instr, proc_in, proc_out, res_data;
    logic       res_valid, res_ready, busy, done, err;
    modport master (
        output load_valid, load_data, prog_clr, start, proc_out, res_ready,
        input  load_ready, instr, proc_in, res_valid, res_data, busy, done, err
    );
    modport slave (
        input  load_valid, load_data, prog_clr, start, proc_out, res_ready,
        output load_ready, instr, proc_in, res_valid, res_data, busy, done, err
    );
endinterface

// File: rtl/instr_sequencer_result_fifo.sv
// result_fifo: 4-entry result queue, built only when RESULT_FIFO_EN is defined.
`ifdef RESULT_FIFO_EN
module result_fifo (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       valid,
    output logic [7:0] data
);
    logic [7:0] mem_q [4];
    logic [1:0] wr_q, wr_d, rd_q, rd_d;
    logic [2:0] cnt_q, cnt_d;
    logic       pop_ok, push_ok;
    assign full    = cnt_q == 3'd4;
    assign valid   = cnt_q != 3'd0;
    assign data    = valid ? mem_q[rd_q] : 8'h00;
    assign pop_ok  = pop && valid;
    // a pop frees the head slot in the same edge, so a full queue may still accept
    assign push_ok = push && (!full || pop_ok);
    always_comb begin
        wr_d  = wr_q + 2'(push_ok);
        rd_d  = rd_q + 2'(pop_ok);
        cnt_d = cnt_q + 3'(push_ok) - 3'(pop_ok);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= push_data;
    end
endmodule
`endif

// File: rtl/instr_sequencer.sv
// instr_sequencer: loads a byte program and replays it to a processor, capturing OUT results.
// Define RESULT_FIFO_EN for a 4-entry result FIFO with back-pressure; otherwise a single result register.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int         PROG_DEPTH = 16,
    parameter logic [7:0] NOP_WORD   = NOP_WORD_DEF
) (
    input logic clk,
    input logic rst,
    instr_sequencer_if.slave bus
);
    localparam int AW = $clog2(PROG_DEPTH);
    typedef logic [AW:0] cnt_t;
    state_t     state_q, state_d;
    cnt_t       len_q, len_d, pc_q, pc_d;
    logic       err_q, err_d;
    logic [7:0] mem_q [PROG_DEPTH];
    logic [AW-1:0] pc_nx;
    logic [7:0] rd_a, rd_b;
    logic       run, active, is_in, trunc, stall, issue_out, load_fire;
    assign pc_nx = pc_q[AW-1:0] + AW'(1);
    assign rd_a  = mem_q[pc_q[AW-1:0]];
    assign rd_b  = mem_q[pc_nx];
    assign run   = state_q == RUN && !rst;
    assign is_in = opcode(rd_a) == OP_IN;
    // an IN in the last slot has no operand word to hand over
    assign trunc = is_in && pc_q == len_q - cnt_t'(1);
`ifdef RESULT_FIFO_EN
    logic fifo_full;
    assign stall = run && opcode(rd_a) == OP_OUT && fifo_full && !bus.res_ready;
`else
    assign stall = 1'b0;
`endif
    assign active    = run && !stall;
    assign issue_out = active && opcode(rd_a) == OP_OUT;
    assign bus.instr   = active ? rd_a : NOP_WORD;
    assign bus.proc_in = active && is_in && !trunc ? rd_b : 8'h00;
    assign bus.load_ready = state_q == IDLE && len_q < cnt_t'(PROG_DEPTH) && !bus.start && !bus.prog_clr;
    assign load_fire = bus.load_valid && bus.load_ready;
    assign bus.busy = state_q == RUN;
    assign bus.done = state_q == DONE;
    assign bus.err  = err_q;
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pc_d    = pc_q;
        err_d   = err_q;
        if (state_q == RUN) begin
            if (!stall) begin
                pc_d    = pc_q + (is_in && !trunc ? cnt_t'(2) : cnt_t'(1));
                err_d   = err_q | trunc;
                state_d = pc_d >= len_q ? DONE : RUN;
            end
        end else if (bus.prog_clr) begin
            len_d   = '0;
            state_d = IDLE;
        end else if (bus.start && len_q != '0) begin
            state_d = RUN;
            pc_d    = '0;
            err_d   = 1'b0;
        end else if (load_fire) begin
            len_d = len_q + cnt_t'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            pc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end
    // program memory is not reset; len=0 makes stale words unreachable
    always_ff @(posedge clk) begin
        if (load_fire) mem_q[len_q[AW-1:0]] <= bus.load_data;
    end
`ifdef RESULT_FIFO_EN
    result_fifo u_result_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue_out),
        .push_data (bus.proc_out),
        .pop       (bus.res_valid && bus.res_ready),
        .full      (fifo_full),
        .valid     (bus.res_valid),
        .data      (bus.res_data)
    );
`else
    logic       res_valid_q, res_valid_d;
    logic [7:0] res_data_q, res_data_d;
    always_comb begin
        res_valid_d = issue_out;
        res_data_d  = issue_out ? bus.proc_out : res_data_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
`endif
endmodule
